// File: rtl/rs232_tx_fifo_if.sv
// rs232_tx_fifo_if
//  Bundles the byte-source side and the transmitter side of rs232_tx_fifo.
//  master : the environment around the FIFO (byte source, flush control and
//           the transmitter's busy line); drives the FIFO inputs.
//  slave  : the FIFO itself.
//  Signals
//   wr_en, wr_data  byte write strobe and data
//   flush           synchronous clear of contents and sticky flags
//   tx_busy         TxD_busy from async_transmitter
//   tx_start        one-cycle TxD_start pulse
//   tx_data         TxD_data, held stable until the next pop
//   full, empty     fill-level decodes
//   level           stored entry count, 0..2**AW
//   overflow        sticky: a write was dropped while full
//   tx_err          sticky: tx_busy failed to rise after tx_start
interface rs232_tx_fifo_if #(
    parameter int DATA_W = 8,
    parameter int AW     = 3
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              flush;
    logic              tx_busy;
    logic              tx_start;
    logic [DATA_W-1:0] tx_data;
    logic              full;
    logic              empty;
    logic [AW:0]       level;
    logic              overflow;
    logic              tx_err;

    modport master (
        output wr_en, wr_data, flush, tx_busy,
        input  tx_start, tx_data, full, empty, level, overflow, tx_err
    );

    modport slave (
        input  wr_en, wr_data, flush, tx_busy,
        output tx_start, tx_data, full, empty, level, overflow, tx_err
    );
endinterface

// File: rtl/rs232_tx_fifo.sv
// rs232_tx_fifo
//  Byte FIFO between a user byte source and async_transmitter. Bytes are
//  accepted at clock rate and released one at a time over the
//  TxD_start/TxD_busy handshake. Fill level, overflow and handshake
//  timeout are reported as registered status.
//  Ports
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    rs232_tx_fifo_if.slave (write port, flush, transmitter handshake,
//          status outputs)
//  Parameters
//   DATA_W byte width, AW address width (DEPTH = 2**AW),
//   TMO    cycles spent in WAIT_HI waiting for tx_busy before flagging tx_err
module rs232_tx_fifo #(
    parameter int DATA_W = 8,
    parameter int AW     = 3,
    parameter int TMO    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    rs232_tx_fifo_if.slave    bus
);
    localparam int DEPTH = 2 ** AW;
    localparam int CW    = (TMO > 1) ? $clog2(TMO) : 1;

    localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TMO - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_reg;
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW:0]       level_reg;
    logic [CW-1:0]     tmo_cnt_reg;
    logic              tx_start_reg;
    logic [DATA_W-1:0] tx_data_reg;
    logic              overflow_reg;
    logic              tx_err_reg;

    logic full_w;
    logic empty_w;
    logic push_w;
    logic pop_w;
    logic timeout_w;

    assign full_w  = (level_reg == LVL_FULL);
    assign empty_w = (level_reg == '0);

    // A write while full is dropped even if a pop frees a slot this cycle,
    // and a write coinciding with flush is simply discarded.
    assign push_w = bus.wr_en && !full_w && !bus.flush;
    assign pop_w  = (state_reg == IDLE) && !empty_w && !bus.tx_busy;

    // Last WAIT_HI cycle with tx_busy still low.
    assign timeout_w = (state_reg == WAIT_HI) && !bus.tx_busy && (tmo_cnt_reg == CNT_LAST);

    // Storage array: no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (push_w) begin
            mem[wr_ptr_reg] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else if (bus.flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_w) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop_w) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({push_w, pop_w})
                2'b10:   level_reg <= level_reg + LVL_ONE;
                2'b01:   level_reg <= level_reg - LVL_ONE;
                default: level_reg <= level_reg;
            endcase
        end
    end

    // Sticky flags; flush takes priority over a same-cycle set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg <= 1'b0;
            tx_err_reg   <= 1'b0;
        end else if (bus.flush) begin
            overflow_reg <= 1'b0;
            tx_err_reg   <= 1'b0;
        end else begin
            if (bus.wr_en && full_w) begin
                overflow_reg <= 1'b1;
            end
            if (timeout_w) begin
                tx_err_reg <= 1'b1;
            end
        end
    end

    // Handshake FSM. It ignores flush so that a byte already handed to the
    // transmitter finishes its handshake; tx_data keeps the last popped byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            tmo_cnt_reg  <= '0;
            tx_start_reg <= 1'b0;
            tx_data_reg  <= '0;
        end else begin
            tx_start_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (pop_w) begin
                        tx_start_reg <= 1'b1;
                        tx_data_reg  <= mem[rd_ptr_reg];
                        state_reg    <= START;
                    end
                end
                START: begin
                    tmo_cnt_reg <= '0;
                    state_reg   <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (bus.tx_busy) begin
                        state_reg <= WAIT_LO;
                    end else if (tmo_cnt_reg == CNT_LAST) begin
                        state_reg <= IDLE;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + CNT_ONE;
                    end
                end
                WAIT_LO: begin
                    if (!bus.tx_busy) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.tx_start = tx_start_reg;
    assign bus.tx_data  = tx_data_reg;
    assign bus.full     = full_w;
    assign bus.empty    = empty_w;
    assign bus.level    = level_reg;
    assign bus.overflow = overflow_reg;
    assign bus.tx_err   = tx_err_reg;
endmodule
